// File: rtl/tx_driver.sv
// Streams a fixed ROM message to the UART transmitter one byte at a time.
// A byte is loaded and XMitGo is pulsed whenever TxEmpty is seen in IDLE; the message repeats forever.
module tx_driver #(
  parameter int MSG_LEN     = 13,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       Enable,
  input  logic       Reset,
  input  logic       TxEmpty,
  output logic       XMitGo,
  output logic [7:0] TxData
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        State, state_nxt;
  logic [AW-1:0] Address, addr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          go_nxt;
  logic [7:0]    data_nxt;

  function automatic logic [7:0] rom(input logic [AW-1:0] a);
    case (int'(a))
      0:       rom = 8'h48;
      1:       rom = 8'h65;
      2:       rom = 8'h6C;
      3:       rom = 8'h6C;
      4:       rom = 8'h6F;
      5:       rom = 8'h2C;
      6:       rom = 8'h20;
      7:       rom = 8'h57;
      8:       rom = 8'h6F;
      9:       rom = 8'h72;
      10:      rom = 8'h6C;
      11:      rom = 8'h64;
      12:      rom = 8'h21;
      default: rom = 8'h00;
    endcase
  endfunction

  // TxData/XMitGo are computed here but only ever leave through the registers below.
  always_comb begin
    state_nxt = State;
    addr_nxt  = Address;
    cnt_nxt   = cnt;
    go_nxt    = 1'b0;
    data_nxt  = TxData;
    case (State)
      IDLE: begin
        if (TxEmpty) begin
          data_nxt  = rom(Address);
          go_nxt    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        addr_nxt  = (Address == ADDR_LAST) ? '0 : Address + 1'b1;
        cnt_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt == CNT_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Enable or negedge Reset) begin
    if (!Reset) begin
      State   <= IDLE;
      Address <= '0;
      cnt     <= '0;
      XMitGo  <= 1'b0;
      TxData  <= 8'h00;
    end else begin
      State   <= state_nxt;
      Address <= addr_nxt;
      cnt     <= cnt_nxt;
      XMitGo  <= go_nxt;
      TxData  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_tx_driver.sv
// Directed bench for tx_driver: reset, message order/spacing, wrap, stall and mid-HOLD reset.
module tb_tx_driver;
  logic       Enable  = 1'b0;
  logic       Reset   = 1'b0;
  logic       TxEmpty = 1'b0;
  logic       XMitGo;
  logic [7:0] TxData;

  int total = 0;
  int bad   = 0;

  logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                           8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

  tx_driver dut (
    .Enable (Enable),
    .Reset  (Reset),
    .TxEmpty(TxEmpty),
    .XMitGo (XMitGo),
    .TxData (TxData)
  );

  always #5 Enable = ~Enable;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge Enable);
      if (XMitGo) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int  last;
    int  np;
    int  p;
    bit  prev_pulse;
    bit  ok;

    // reset held with TxEmpty low
    repeat (10) @(negedge Enable);
    chk("rst_go", XMitGo, 0);
    chk("rst_data", TxData, 8'h00);
    chk("rst_addr", dut.Address, 0);
    chk("rst_state", dut.State, 0);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Enable);
      chk("idle_go", XMitGo, 0);
    end
    chk("idle_addr", dut.Address, 0);
    chk("idle_state", dut.State, 0);
    chk("idle_data", TxData, 8'h00);

    // first character
    TxEmpty = 1'b1;
    @(negedge Enable);
    chk("first_go", XMitGo, 1);
    chk("first_data", TxData, 8'h48);
    @(negedge Enable);
    chk("first_go_low", XMitGo, 0);
    chk("first_addr", dut.Address, 1);

    // full message plus wrap, pulses expected every 4 cycles
    last = 0;
    np = 1;
    prev_pulse = 1'b0;
    for (int c = 2; c <= 57; c++) begin
      @(negedge Enable);
      if (prev_pulse) chk("addr_adv", dut.Address, np % 13);
      prev_pulse = 1'b0;
      if (XMitGo) begin
        chk("gap", c - last, 4);
        chk("char", TxData, msg[np % 13]);
        last = c;
        np++;
        prev_pulse = 1'b1;
      end else begin
        chk("stable", TxData, msg[(np - 1) % 13]);
      end
    end
    chk("npulse", np, 15);

    // stall: TxEmpty dropped during HOLD
    TxEmpty = 1'b0;
    p = 0;
    repeat (20) begin
      @(negedge Enable);
      if (XMitGo) p++;
    end
    chk("stall_pulses", p, 0);
    chk("stall_addr", dut.Address, 2);
    chk("stall_state", dut.State, 0);
    TxEmpty = 1'b1;
    wait_pulse(8, ok);
    chk("resume_seen", ok, 1);
    chk("resume_char", TxData, msg[2]);

    // reach HOLD with Address=5, then reset asynchronously
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge Enable);
      if (dut.State == 2'd2 && dut.Address == 4'd5) ok = 1'b1;
    end
    chk("reach_a5", ok, 1);
    Reset = 1'b0;
    #1;
    chk("arst_go", XMitGo, 0);
    chk("arst_data", TxData, 8'h00);
    chk("arst_addr", dut.Address, 0);
    chk("arst_state", dut.State, 0);
    @(negedge Enable);
    Reset = 1'b1;
    wait_pulse(8, ok);
    chk("post_rst_seen", ok, 1);
    chk("post_rst_char", TxData, 8'h48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
